// File: rtl/stepper_if.sv
// Control/status bundle between the user control logic and stepper_sequencer.
//   master modport: user side (drives the command, observes status)
//   slave  modport: sequencer side
// Signals:
//   start      command request (level-sampled)
//   stop       abort request, wins over start in the same cycle
//   dir        1 = forward, 0 = reverse
//   steps      number of phase advances for the move
//   period     clocks per phase advance (0 behaves as 1)
//   cnt        2-bit phase index for the coil-phase decoder
//   step_pulse 1-cycle strobe coincident with each cnt change
//   busy       high while steps remain
//   done       1-cycle strobe at the end of a move (normal, aborted or empty)
//   en         coil driver enable
interface stepper_if #(
  parameter int STEPS_W  = 16,
  parameter int PERIOD_W = 16
);
  logic                start;
  logic                stop;
  logic                dir;
  logic [STEPS_W-1:0]  steps;
  logic [PERIOD_W-1:0] period;
  logic [1:0]          cnt;
  logic                step_pulse;
  logic                busy;
  logic                done;
  logic                en;

  modport master (
    output start, stop, dir, steps, period,
    input  cnt, step_pulse, busy, done, en
  );

  modport slave (
    input  start, stop, dir, steps, period,
    output cnt, step_pulse, busy, done, en
  );
endinterface

// File: rtl/stepper_sequencer.sv
// Stepper phase sequencer.
// Issues a programmed number of phase advances on the 2-bit phase index, one
// every PERIOD clocks in the requested direction, then keeps the coils
// energised for HOLD_CYCLES clocks before dropping the driver enable.
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst    asynchronous, active-high reset
//   if_step  command/status bundle (slave side), see stepper_if
//   o_state  current FSM state (0 = IDLE, 1 = RUN, 2 = HOLD) for observation
//
// Handshake: start acts as a level "valid" with an implicit "ready" that is
// high only in IDLE and HOLD; a command is taken on any rising edge where
// start=1, stop=0 and the sequencer is ready. While RUN is active start is
// ignored, so a held start simply waits for the next IDLE/HOLD cycle.
module stepper_sequencer #(
  parameter int STEPS_W     = 16,
  parameter int PERIOD_W    = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  stepper_if.slave   if_step,
  output logic [1:0] o_state
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // The hold counter is loaded with HOLD_CYCLES-1 and exits when it reads 0,
  // giving exactly HOLD_CYCLES clocks of enable after the final step.
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state,  w_state_nx;
  logic [1:0]          r_cnt,    w_cnt_nx;
  logic                r_pulse,  w_pulse_nx;
  logic                r_busy,   w_busy_nx;
  logic                r_done,   w_done_nx;
  logic                r_en,     w_en_nx;
  logic                r_dir,    w_dir_nx;
  logic [STEPS_W-1:0]  r_rem,    w_rem_nx;
  logic [PERIOD_W-1:0] r_period, w_period_nx;
  logic [PERIOD_W-1:0] r_timer,  w_timer_nx;
  logic [HOLD_W-1:0]   r_hold,   w_hold_nx;

  logic [PERIOD_W-1:0] w_period_eff;
  logic                w_accept;
  logic                w_empty_req;
  logic                w_finish;

  // A zero period is promoted to one so the timer never underflows.
  assign w_period_eff = (if_step.period == '0) ? PERIOD_W'(1) : if_step.period;
  assign w_accept     = if_step.start && !if_step.stop && (if_step.steps != '0);
  assign w_empty_req  = if_step.start && !if_step.stop && (if_step.steps == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_en     <= 1'b0;
      r_dir    <= 1'b0;
      r_rem    <= '0;
      r_period <= '0;
      r_timer  <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_pulse  <= w_pulse_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_en     <= w_en_nx;
      r_dir    <= w_dir_nx;
      r_rem    <= w_rem_nx;
      r_period <= w_period_nx;
      r_timer  <= w_timer_nx;
      r_hold   <= w_hold_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_pulse_nx  = 1'b0;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_en_nx     = r_en;
    w_dir_nx    = r_dir;
    w_rem_nx    = r_rem;
    w_period_nx = r_period;
    w_timer_nx  = r_timer;
    w_hold_nx   = r_hold;
    w_finish    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx  = ST_RUN;
          w_busy_nx   = 1'b1;
          w_en_nx     = 1'b1;
          w_dir_nx    = if_step.dir;
          w_rem_nx    = if_step.steps;
          w_period_nx = w_period_eff;
          w_timer_nx  = w_period_eff - PERIOD_W'(1);
        end else if (w_empty_req) begin
          w_done_nx = 1'b1;
        end
      end

      ST_RUN: begin
        if (if_step.stop) begin
          w_finish = 1'b1;
        end else if (r_timer == '0) begin
          w_cnt_nx   = r_dir ? (r_cnt + 2'd1) : (r_cnt - 2'd1);
          w_pulse_nx = 1'b1;
          w_timer_nx = r_period - PERIOD_W'(1);
          if (r_rem == STEPS_W'(1)) begin
            w_rem_nx = '0;
            w_finish = 1'b1;
          end else begin
            w_rem_nx = r_rem - STEPS_W'(1);
          end
        end else begin
          w_timer_nx = r_timer - PERIOD_W'(1);
        end
      end

      ST_HOLD: begin
        if (if_step.stop) begin
          w_state_nx = ST_IDLE;
          w_en_nx    = 1'b0;
        end else if (w_accept) begin
          // Back-to-back move: enable stays high across the transition.
          w_state_nx  = ST_RUN;
          w_busy_nx   = 1'b1;
          w_dir_nx    = if_step.dir;
          w_rem_nx    = if_step.steps;
          w_period_nx = w_period_eff;
          w_timer_nx  = w_period_eff - PERIOD_W'(1);
        end else begin
          if (w_empty_req) begin
            w_done_nx = 1'b1;
          end
          if (r_hold == '0) begin
            w_state_nx = ST_IDLE;
            w_en_nx    = 1'b0;
          end else begin
            w_hold_nx = r_hold - HOLD_W'(1);
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
        w_en_nx    = 1'b0;
      end
    endcase

    // End of move, shared by the last step and an abort.
    if (w_finish) begin
      w_busy_nx = 1'b0;
      w_done_nx = 1'b1;
      if (HOLD_CYCLES == 0) begin
        w_state_nx = ST_IDLE;
        w_en_nx    = 1'b0;
      end else begin
        w_state_nx = ST_HOLD;
        w_hold_nx  = HOLD_LOAD;
      end
    end
  end

  assign if_step.cnt        = r_cnt;
  assign if_step.step_pulse = r_pulse;
  assign if_step.busy       = r_busy;
  assign if_step.done       = r_done;
  assign if_step.en         = r_en;
  assign o_state            = r_state;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer.
// Expected phase steps ({edge cycle, cnt}) are queued when a move is issued
// and popped by a monitor whenever the sequencer strobes step_pulse.
module tb_stepper_sequencer;
  localparam int STEPS_W  = 16;
  localparam int PERIOD_W = 16;
  localparam int HOLD     = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  stepper_if #(.STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W)) u_if();

  stepper_sequencer #(
    .STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk(clk), .i_rst(rst), .if_step(u_if.slave), .o_state(state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  logic [1:0]  model_cnt;
  int unsigned done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && u_if.step_pulse === 1'b1) begin
      check("step_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("step_cycle", cyc, mon_e[33:2]);
        check("step_cnt", 32'(u_if.cnt), 32'(mon_e[1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue a move; abort_after>0 stops it after that many steps; noisy
  // scrambles the command inputs (and pulses start) while it runs.
  task automatic run_move(input logic d, input int n, input int p,
                          input int abort_after, input bit noisy);
    int unsigned t, pe, done_exp, limit, nsteps;
    int  seen;
    bit  got, stopped;
    pe     = (p == 0) ? 1 : p;
    nsteps = (abort_after > 0) ? abort_after : n;
    @(negedge clk);
    t = cyc + 1;
    for (int unsigned k = 1; k <= nsteps; k++) begin
      model_cnt = d ? model_cnt + 2'd1 : model_cnt - 2'd1;
      exp_q.push_back({32'(t + k * pe), model_cnt});
    end
    done_exp = (abort_after > 0) ? t + nsteps * pe + 1 : t + nsteps * pe;
    limit    = nsteps * pe + 10;
    u_if.dir    = d;
    u_if.steps  = STEPS_W'(n);
    u_if.period = PERIOD_W'(p);
    u_if.start  = 1'b1;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    seen = 0; got = 1'b0; stopped = 1'b0;
    for (int i = 0; i < int'(limit) && !got; i++) begin
      @(negedge clk);
      if (u_if.step_pulse) seen++;
      if (u_if.done) begin
        got      = 1'b1;
        done_cyc = cyc;
        u_if.start = 1'b0;
        check("done_cycle", cyc, done_exp);
        check("busy_at_done", 32'(u_if.busy), 0);
      end else begin
        check("busy_run", 32'(u_if.busy), 1);
        check("en_run", 32'(u_if.en), 1);
        if (noisy) begin
          u_if.start  = 1'($urandom_range(0, 1));
          u_if.dir    = 1'($urandom_range(0, 1));
          u_if.steps  = STEPS_W'($urandom_range(0, 20));
          u_if.period = PERIOD_W'($urandom_range(0, 9));
        end
        if (abort_after > 0 && seen == abort_after && !stopped) begin
          stopped   = 1'b1;
          u_if.stop = 1'b1;
          @(posedge clk);
          #1;
          u_if.stop  = 1'b0;
          u_if.start = 1'b0;
        end
      end
    end
    check("done_seen", 32'(got), 1);
    @(negedge clk);
    check("done_1cycle", 32'(u_if.done), 0);
    check("q_drained", exp_q.size(), 0);
    check("en_hold", 32'(u_if.en), 1);
  endtask

  task automatic wait_idle();
    bit off = 1'b0;
    for (int i = 0; i < HOLD + 10 && !off; i++) begin
      @(negedge clk);
      if (!u_if.en) off = 1'b1;
    end
    check("en_release", 32'(off), 1);
    check("hold_len", cyc - done_cyc, HOLD);
    check("state_idle", 32'(state), 0);
  endtask

  task automatic zero_steps();
    int unsigned t;
    @(negedge clk);
    t = cyc + 1;
    u_if.dir   = 1'b1;
    u_if.steps = '0;
    u_if.start = 1'b1;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(u_if.done), 1);
    check("zero_done_cyc", cyc, t);
    check("zero_busy", 32'(u_if.busy), 0);
    check("zero_en", 32'(u_if.en), 0);
    check("zero_cnt", 32'(u_if.cnt), 32'(model_cnt));
    @(negedge clk);
    check("zero_done_1cycle", 32'(u_if.done), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    u_if.start = 1'b0; u_if.stop = 1'b0; u_if.dir = 1'b0;
    u_if.steps = '0;   u_if.period = '0;
    model_cnt = 2'd0;
    done_cyc  = 0;
    repeat (2) @(negedge clk);
    check("rst_cnt", 32'(u_if.cnt), 0);
    check("rst_pulse", 32'(u_if.step_pulse), 0);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_done", 32'(u_if.done), 0);
    check("rst_en", 32'(u_if.en), 0);
    check("rst_state", 32'(state), 0);
    rst = 1'b0;

    run_move(1'b1, 5, 4, 0, 1'b0);     // forward 5 steps, period 4
    wait_idle();
    run_move(1'b0, 3, 1, 0, 1'b0);     // reverse, back-to-back edges
    wait_idle();
    zero_steps();
    run_move(1'b1, 2, 0, 0, 1'b0);     // period 0 behaves as 1
    wait_idle();
    run_move(1'b1, 10, 8, 2, 1'b1);    // abort after 2 steps, start noise
    wait_idle();

    run_move(1'b1, 3, 2, 0, 1'b0);     // new move issued during HOLD
    repeat (3) begin
      @(negedge clk);
      check("en_hold_gap", 32'(u_if.en), 1);
    end
    run_move(1'b0, 4, 3, 0, 1'b0);
    wait_idle();

    run_move(1'b0, 6, 3, 0, 1'b1);     // inputs scrambled during RUN
    wait_idle();

    // Asynchronous reset in the middle of a move (phase is non-zero here).
    @(negedge clk);
    u_if.dir = 1'b1; u_if.steps = 16'd10; u_if.period = 16'd8; u_if.start = 1'b1;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(u_if.busy), 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(u_if.cnt), 0);
    check("async_rst_busy", 32'(u_if.busy), 0);
    check("async_rst_en", 32'(u_if.en), 0);
    check("async_rst_done", 32'(u_if.done), 0);
    check("async_rst_pulse", 32'(u_if.step_pulse), 0);
    model_cnt = 2'd0;
    exp_q.delete();
    @(negedge clk);
    check("rst_no_done", 32'(u_if.done), 0);
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      run_move(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
               int'($urandom_range(0, 5)), 0, 1'b0);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
